// File: rtl/rf_pkg.sv
// Shared types, default parameters and write-port priority helper for rf_multiport.
package rf_pkg;

   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_IDLE  = 1'b1
   } rf_state_t;

   localparam int RF_DW_DEF = 32;
   localparam int RF_AW_DEF = 5;
   localparam int RF_NR_DEF = 2;
   localparam int RF_NW_DEF = 2;

   // Helper operates on port/address lanes padded to these maxima.
   localparam int RF_MAX_NW = 4;
   localparam int RF_MAX_AW = 16;

   typedef struct packed {
      logic       hit;
      logic [1:0] idx;
   } rf_pri_t;

   // Highest-index enabled port whose address matches wins.
   function automatic rf_pri_t pri_match(
      input logic [RF_MAX_NW-1:0]           we,
      input logic [RF_MAX_NW*RF_MAX_AW-1:0] wa,
      input logic [RF_MAX_AW-1:0]           addr
   );
      rf_pri_t res;
      res = '0;
      for (int j = 0; j < RF_MAX_NW; j++) begin
         if (we[j] && (wa[j*RF_MAX_AW +: RF_MAX_AW] == addr)) begin
            res.hit = 1'b1;
            res.idx = 2'(j);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks every entry once after reset or clr_req, then
// reports ready.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RF_CLEAR | zeroing entry cnt each edge; reads forced 0, writes dropped
//   RF_IDLE  | array usable; clr_req restarts the sweep from entry 0
module rf_clear_seq
   import rf_pkg::*;
#(
   parameter int AW = RF_AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          ready,
   output logic          clr_active,
   output logic [AW-1:0] clr_addr,
   output logic          clr_we
);

   rf_state_t     state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          ready_q, ready_d;

   // State, sweep counter and ready flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RF_CLEAR;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   // Next-state: sweep to the last entry, then idle until a clear request.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      case (state_q)
         RF_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {AW{1'b1}}) begin
               state_d = RF_IDLE;
               ready_d = 1'b1;
            end
         end
         RF_IDLE: begin
            if (clr_req) begin
               state_d = RF_CLEAR;
               cnt_d   = '0;
               ready_d = 1'b0;
            end
         end
         default: begin
            state_d = RF_CLEAR;
            cnt_d   = '0;
            ready_d = 1'b0;
         end
      endcase
   end

   assign ready      = ready_q;
   assign clr_active = (state_q == RF_CLEAR);
   assign clr_addr   = cnt_q;
   assign clr_we     = clr_active;

endmodule

// File: rtl/rf_multiport.sv
// Multi-port register file: NR combinational read ports, NW write ports with
// highest-index priority, optional bypass and hard-wired zero register.
module rf_multiport
   import rf_pkg::*;
#(
   parameter int DW       = RF_DW_DEF,
   parameter int AW       = RF_AW_DEF,
   parameter int NR       = RF_NR_DEF,
   parameter int NW       = RF_NW_DEF,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NR*AW-1:0] ra,
   output logic [NR*DW-1:0] rd,
   input  logic [NW-1:0]    we,
   input  logic [NW*AW-1:0] wa,
   input  logic [NW*DW-1:0] wd,
   input  logic           clr_req,
   output logic           ready
);

   localparam int DEPTH = 2**AW;

   logic          clr_active;
   logic [AW-1:0] clr_addr;
   logic          clr_we;
   logic          wr_ok;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];

   logic [RF_MAX_NW-1:0]           we_ext;
   logic [RF_MAX_NW*RF_MAX_AW-1:0] wa_ext;
   logic [RF_MAX_NW*DW-1:0]        wd_ext;

   rf_clear_seq #(.AW(AW)) u_clear_seq (
      .clk        (clk),
      .rst        (rst),
      .clr_req    (clr_req),
      .ready      (ready),
      .clr_active (clr_active),
      .clr_addr   (clr_addr),
      .clr_we     (clr_we)
   );

   // A clear request wins over writes presented in the same cycle, and
   // such writes are not bypassed either since they never land.
   assign wr_ok = !clr_active && !clr_req;

   // Pad write ports to the helper's fixed lane widths; zero-register
   // writes are masked here so they neither store nor bypass.
   always_comb begin
      we_ext = '0;
      wa_ext = '0;
      wd_ext = '0;
      for (int j = 0; j < NW; j++) begin
         we_ext[j] = we[j] && wr_ok && !(ZERO_REG && (wa[j*AW +: AW] == '0));
         wa_ext[j*RF_MAX_AW +: RF_MAX_AW] = RF_MAX_AW'(wa[j*AW +: AW]);
         wd_ext[j*DW +: DW] = wd[j*DW +: DW];
      end
   end

   // Next array contents: clear sweep or prioritised writes (later port
   // assignments overwrite earlier ones, so the highest index wins).
   always_comb begin
      mem_d = mem_q;
      if (clr_we) begin
         mem_d[clr_addr] = '0;
      end else begin
         for (int j = 0; j < NW; j++) begin
            if (we_ext[j]) begin
               mem_d[wa[j*AW +: AW]] = wd[j*DW +: DW];
            end
         end
      end
   end

   // Storage has no reset; the clear sequencer initialises it.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   for (genvar i = 0; i < NR; i++) begin : g_rd
      logic [AW-1:0] ra_i;
      logic [DW-1:0] rd_i;
      rf_pri_t       pm;

      assign ra_i = ra[i*AW +: AW];

      // Read mux: clear forces 0, then zero register, then bypass, then array.
      always_comb begin
         pm   = pri_match(we_ext, wa_ext, RF_MAX_AW'(ra_i));
         rd_i = mem_q[ra_i];
         if (clr_active) begin
            rd_i = '0;
         end else if (ZERO_REG && (ra_i == '0)) begin
            rd_i = '0;
         end else if (BYPASS && pm.hit) begin
            rd_i = wd_ext[pm.idx*DW +: DW];
         end
      end

      assign rd[i*DW +: DW] = rd_i;
   end

endmodule
